// File: rtl/lc3b_mem_responder_if.sv
// Memory-port bundle between the LC-3b datapath/control (master) and the memory responder (slave).
interface lc3b_mem_responder_if;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, proto_err
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, proto_err
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Word-organized RAM answering LC-3b memory requests with a one-cycle mem_resp after LATENCY cycles.
// Define LC3B_MEM_PROTO_CHECK_EN to build the sticky protocol-error checker driving proto_err.
module lc3b_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  lc3b_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : '0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        resp_q, resp_d;
  logic        enter_resp;
  logic        req;
  logic        do_write;
  logic [ADDR_W-1:0] idx;
  logic [15:0] ram [2**ADDR_W];
  logic        unused_addr_bits;

  assign idx      = bus.mem_address[ADDR_W:1];
  assign req      = bus.mem_read | bus.mem_write;
  // Simultaneous read/write resolves as a read, so the write side is masked.
  assign do_write = enter_resp & bus.mem_write & ~bus.mem_read;
  assign unused_addr_bits = ^{bus.mem_address[0], bus.mem_address >> (ADDR_W + 1)};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_d  = enter_resp;
    rdata_d = (enter_resp && bus.mem_read) ? ram[idx] : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  // RAM contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      if (bus.mem_byte_enable[0]) ram[idx][7:0]  <= bus.mem_wdata[7:0];
      if (bus.mem_byte_enable[1]) ram[idx][15:8] <= bus.mem_wdata[15:8];
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = resp_q;

`ifdef LC3B_MEM_PROTO_CHECK_EN
  logic        perr_q, perr_d;
  logic [15:0] addr_prev_q, wdata_prev_q;
  logic [1:0]  be_prev_q;

  // The *_prev_q copies hold last cycle's inputs so any change while waiting is visible.
  always_comb begin
    perr_d = perr_q | (bus.mem_read & bus.mem_write);
    if (state_q == WAIT) begin
      perr_d = perr_d | ~req
             | (bus.mem_address     != addr_prev_q)
             | (bus.mem_wdata       != wdata_prev_q)
             | (bus.mem_byte_enable != be_prev_q);
    end
  end

  always_ff @(posedge clk) begin
    addr_prev_q  <= bus.mem_address;
    wdata_prev_q <= bus.mem_wdata;
    be_prev_q    <= bus.mem_byte_enable;
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign bus.proto_err = perr_q;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Randomized bench for lc3b_mem_responder: three instances (LATENCY 2, 4, 1) checked against a RAM/handshake model.
module tb_lc3b_mem_responder;

`ifdef LC3B_MEM_PROTO_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [15:0] addr  [3];
  logic [15:0] wd    [3];
  logic [1:0]  be    [3];
  logic [15:0] rdata [3];
  logic        resp  [3];
  logic        perr  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lc3b_mem_responder_if bus ();
    assign bus.mem_address     = addr[g];
    assign bus.mem_read        = rd[g];
    assign bus.mem_write       = wr[g];
    assign bus.mem_byte_enable = be[g];
    assign bus.mem_wdata       = wd[g];
    assign rdata[g] = bus.mem_rdata;
    assign resp[g]  = bus.mem_resp;
    assign perr[g]  = bus.proto_err;
    lc3b_mem_responder #(
      .ADDR_W (8),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 4 : 1))
    ) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .bus(bus.slave)
    );
  end

  // Reference model: plain word array, last read value and sticky error per instance.
  logic [15:0] mdl [3][256];
  logic [15:0] mrd [3];
  bit          merr[3];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check({tag, "_resp"}, 32'(resp[k]), 32'd0);
    check({tag, "_rdata"}, 32'(rdata[k]), 32'(mrd[k]));
    check({tag, "_perr"}, 32'(perr[k]), 32'(CHK & merr[k]));
  endtask

  task automatic txn(input int k, input bit r, input bit w, input logic [15:0] a,
                     input logic [1:0] b, input logic [15:0] d);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    rd[k] = r; wr[k] = w; addr[k] = a; be[k] = b; wd[k] = d;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (resp[k]) begin
        cyc = i;
        break;
      end
    end
    check("latency", 32'(cyc), 32'(lat_of(k)));
    if (r) begin
      mrd[k] = mdl[k][a[8:1]];
    end else if (w) begin
      if (b[0]) mdl[k][a[8:1]][7:0]  = d[7:0];
      if (b[1]) mdl[k][a[8:1]][15:8] = d[15:8];
    end
    if (r && w) merr[k] = 1'b1;
    check("rdata", 32'(rdata[k]), 32'(mrd[k]));
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs(k, "after");
  endtask

  task automatic abort_write(input int k, input logic [15:0] a, input logic [15:0] d, input int drop_cyc);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    wr[k] = 1'b1; addr[k] = a; be[k] = 2'b11; wd[k] = d;
    for (int i = 1; i <= drop_cyc; i++) begin
      @(posedge clk); #1;
      if (resp[k]) seen = 1'b1;
    end
    wr[k] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp[k]) seen = 1'b1;
    end
    merr[k] = 1'b1;
    check("abort_noresp", 32'(seen), 32'd0);
    check_idle_outputs(k, "abort");
  endtask

  task automatic reset_mid_write(input int k, input logic [15:0] a);
    @(posedge clk); #1;
    wr[k] = 1'b1; addr[k] = a; be[k] = 2'b11; wd[k] = 16'hFFFF;
    @(posedge clk); #1;
    rst[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0; wr[k] = 1'b0;
    mrd[k] = 16'h0000; merr[k] = 1'b0;
    check_idle_outputs(k, "rst_wait");
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0;
      addr[k] = '0; wd[k] = '0; be[k] = '0;
      mrd[k] = 16'h0000; merr[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    for (int k = 0; k < 3; k++) check_idle_outputs(k, "reset");

    // Fill every word so later reads have defined contents.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 256; i++)
        txn(k, 1'b0, 1'b1, 16'(i << 1), 2'b11, 16'($urandom));

    // Full-word write/read and byte-enable merges.
    txn(0, 0, 1, 16'h0040, 2'b11, 16'h1234);
    txn(0, 1, 0, 16'h0040, 2'b00, 16'h0000);
    check("plan_full", 32'(rdata[0]), 32'h1234);
    txn(0, 0, 1, 16'h0040, 2'b01, 16'hABCD);
    txn(0, 1, 0, 16'h0040, 2'b00, 16'h0000);
    check("plan_be01", 32'(rdata[0]), 32'h12CD);
    txn(0, 0, 1, 16'h0040, 2'b10, 16'h5600);
    txn(0, 1, 0, 16'h0040, 2'b00, 16'h0000);
    check("plan_be10", 32'(rdata[0]), 32'h56CD);
    txn(0, 0, 1, 16'h0040, 2'b00, 16'hFFFF);
    txn(0, 1, 0, 16'h0040, 2'b00, 16'h0000);
    check("plan_be00", 32'(rdata[0]), 32'h56CD);

    // Aliasing of upper address bits and bit 0.
    txn(0, 0, 1, 16'h0202, 2'b11, 16'hBEEF);
    txn(0, 1, 0, 16'h0002, 2'b00, 16'h0000);
    check("alias_even", 32'(rdata[0]), 32'hBEEF);
    txn(0, 1, 0, 16'h0003, 2'b00, 16'h0000);
    check("alias_odd", 32'(rdata[0]), 32'hBEEF);

    // Dropped write on the LATENCY=4 instance, then a normal read.
    txn(1, 0, 1, 16'h0080, 2'b11, 16'h1111);
    abort_write(1, 16'h0080, 16'h7777, 2);
    txn(1, 1, 0, 16'h0080, 2'b00, 16'h0000);
    check("abort_ram", 32'(rdata[1]), 32'h1111);

    // Reset while waiting, including at the RESP-entry edge for LATENCY=2.
    reset_mid_write(1, 16'h0080);
    txn(1, 1, 0, 16'h0080, 2'b00, 16'h0000);
    check("rst_ram1", 32'(rdata[1]), 32'h1111);
    reset_mid_write(0, 16'h0040);
    txn(0, 1, 0, 16'h0040, 2'b00, 16'h0000);
    check("rst_ram0", 32'(rdata[0]), 32'h56CD);

    // LATENCY=1 read.
    txn(2, 0, 1, 16'h0010, 2'b11, 16'hC0DE);
    txn(2, 1, 0, 16'h0010, 2'b00, 16'h0000);
    check("lat1_read", 32'(rdata[2]), 32'hC0DE);

    // Read and write together resolve as a read.
    txn(0, 0, 1, 16'h00AA, 2'b11, 16'h00AA);
    txn(0, 1, 1, 16'h00AA, 2'b11, 16'h5555);
    check("both_rdata", 32'(rdata[0]), 32'h00AA);
    txn(0, 1, 0, 16'h00AA, 2'b00, 16'h0000);
    check("both_ram", 32'(rdata[0]), 32'h00AA);

    // Random traffic across all instances.
    for (int n = 0; n < 400; n++) begin
      int k;
      int sel;
      bit r, w;
      k   = int'($urandom_range(2, 0));
      sel = int'($urandom_range(19, 0));
      r   = (sel < 9) || (sel == 19);
      w   = (sel >= 9);
      txn(k, r, w, 16'($urandom), 2'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
- Synthesizable memory-side responder for the LC-3b multicycle datapath's memory port.
- Receives mem_read/mem_write requests from the control unit and datapath, holds a word-organized RAM, and returns a one-cycle mem_resp after a programmable latency.
- Used as on-chip memory in synthesis builds and as the memory model in CPU-level benches.

Parameters:
- ADDR_W, 8, number of word-index bits; depth = 2^ADDR_W 16-bit words.
- LATENCY, 2, cycles from first request cycle to the mem_resp cycle; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- mem_address  input  16  byte address; bit 0 ignored; bits [ADDR_W:1] select the word; upper bits ignored (aliasing wrap)
- mem_read  input  1  read request, held high until mem_resp
- mem_write  input  1  write request, held high until mem_resp
- mem_byte_enable  input  2  bit1 = high byte [15:8], bit0 = low byte [7:0]; writes only
- mem_wdata  input  16  write data
- mem_rdata  output  16  read data, valid in the mem_resp cycle
- mem_resp  output  1  one-cycle completion pulse
- proto_err  output  1  sticky protocol-error flag; see Optional Feature

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE, mem_resp = 0, mem_rdata = 16'h0000, counter = 0, proto_err = 0.
  - RAM contents are not cleared.
  - rst overrides every other input.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read | mem_write is high in cycle 0, the request is accepted.
  - Accept goes to RESP if LATENCY = 1; otherwise to WAIT with counter = LATENCY-2.
- WAIT:
  - Request still high: counter decrements each cycle; go to RESP when counter = 0.
  - Request dropped: abort to IDLE, with no write and no mem_resp.
- Entry into RESP (edge ending cycle LATENCY-1):
  - Read: mem_rdata <= RAM[mem_address[ADDR_W:1]].
  - Write: for each set mem_byte_enable bit, the corresponding byte of mem_wdata is written to the addressed word.
  - Address, data and enables are sampled at this edge only; the requester holds them stable throughout.
- RESP:
  - mem_resp = 1 for exactly one cycle (cycle LATENCY); next state is IDLE unconditionally.
  - A request present in the cycle after RESP is a new request; the control FSM drops its request in that cycle.
- Total latency: mem_resp is high in cycle LATENCY, counted from the first request cycle (cycle 0).
- mem_rdata holds its last loaded value outside RESP; writes do not change mem_rdata.
- mem_read and mem_write both high: treated as a read; the write is discarded.
- mem_byte_enable = 2'b00 on a write: completes normally (mem_resp pulses) with no RAM change.
- Read-after-write to the same word in consecutive transactions returns the new data; no bypass is needed because transactions never overlap.
- rst during WAIT or RESP: abort; no write occurs if rst is high at the RESP-entry edge.

Optional Feature:
- Macro: LC3B_MEM_PROTO_CHECK_EN.
- Defined: proto_err is set (sticky until rst) when any of the following occurs:
  - mem_read and mem_write are high together in any cycle;
  - a request drops in WAIT before mem_resp;
  - mem_address, mem_wdata or mem_byte_enable change while in WAIT.
- Undefined: proto_err is tied to 0 and no checker logic is generated.
- Functional behaviour is identical either way.

Test Plan:
- LATENCY=2, write addr 16'h0040, wdata 16'h1234, be 2'b11 -> mem_resp high exactly in cycle 2; read 16'h0040 -> mem_rdata 16'h1234 with mem_resp in cycle 2.
- Preload 16'h1234 at 16'h0040, write wdata 16'hABCD be 2'b01 -> read returns 16'h12CD; be 2'b10 with 16'h5600 -> read returns 16'h56CD; be 2'b00 -> unchanged, mem_resp still pulses.
- ADDR_W=8, write 16'hBEEF at 16'h0202 -> read at 16'h0002 and 16'h0003 both return 16'hBEEF (aliasing and bit-0 ignore).
- LATENCY=4, write request dropped in cycle 2 -> no mem_resp, RAM unchanged, proto_err=1 with macro and 0 without; next read completes normally in cycle 4.
- rst asserted during WAIT of a write of 16'hFFFF -> outputs reset values next cycle, RAM keeps old word; LATENCY=1 read -> mem_resp in cycle 1.
- mem_read and mem_write both high, addr holding 16'h00AA, wdata 16'h5555 -> mem_rdata 16'h00AA, RAM unchanged, proto_err=1 with macro.
